button_repeater: RTL and testbench
==================================

# button_repeater

Converts the clean level from the button debouncer into cursor-step events for the etch-a-sketch drawing logic. On press it emits one step pulse immediately. If the button stays held past a hold delay, it emits auto-repeat steps at a fixed rate until release. It also reports press and release edges and a repeating flag, so the drawing logic never handles raw levels or timing.

## Interface
- `HOLD_TICKS`, default 6_000_000: clocks from the press step to the first repeat step (0.5 s at 12 MHz); must be ≥2.
- `REPEAT_TICKS`, default 1_200_000: clocks between consecutive repeat steps (100 ms at 12 MHz); must be ≥2.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `debounced_in` input, 1: clean button level from the debouncer, synchronous to `clk`.
- `enable` input, 1: when low, suppresses all events and holds the FSM in IDLE.
- `step` output, 1: one-cycle pulse per cursor step (press plus each repeat).
- `pressed` output, 1: one-cycle pulse on the rising edge of `debounced_in`.
- `released` output, 1: one-cycle pulse on the falling edge of `debounced_in`.
- `repeating` output, 1: level, high while the FSM is in REPEAT.

## Operation
- `in_q` register holds the previous `debounced_in`.
  - It updates every cycle, including while `enable` is low.
  - Rise = `debounced_in & ~in_q`; fall = `~debounced_in & in_q`.
- Tick counter width is `$clog2(max(HOLD_TICKS, REPEAT_TICKS))`; it never exceeds its terminal value.
- FSM states: IDLE, DELAY, REPEAT.
- IDLE:
  - On rise with `enable` high: `step`=1, `pressed`=1, counter←0, go to DELAY.
  - Otherwise stay in IDLE.
- DELAY:
  - On fall: `released`=1, counter←0, go to IDLE.
  - Else if counter == HOLD_TICKS−1: `step`=1, counter←0, go to REPEAT.
  - Else counter++.
- REPEAT:
  - On fall: `released`=1, counter←0, go to IDLE.
  - Else if counter == REPEAT_TICKS−1: `step`=1, counter←0.
  - Else counter++.
- Release wins over a terminal count on the same edge: no `step` is emitted.
- `enable` low in any state:
  - Next state is IDLE, counter←0.
  - `step`, `pressed`, `released` are forced 0.
  - If the button is still held when `enable` rises, no press is generated (`in_q` is already 1). Events resume only after a release and a new press.
- Reset: state IDLE, counter 0, `in_q` 0, and every output 0.
  - Reset mid-hold: after deassertion with `debounced_in` still 1, the first clock samples a rise and restarts the press sequence.

## Timing
- All outputs are registered, so latency is exactly one cycle.
  - A rise sampled at edge k gives `step`/`pressed` high from edge k to edge k+1.
- First repeat `step` is registered at edge k+HOLD_TICKS.
- Subsequent repeat steps are at k+HOLD_TICKS+n·REPEAT_TICKS.
- `repeating` goes high at edge k+HOLD_TICKS and goes low on the edge that samples the fall.
- `released` is registered on the edge that samples the fall.
- A press shorter than HOLD_TICKS gives exactly one `step`.
- Back-to-back fall then rise on consecutive edges is legal: `released` and then `pressed` pulse in consecutive cycles.

## Structure
- Package `button_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} repeater_state_t;`
  - Default tick constants for a 12 MHz clock.
- Sub-module `edge_detector` (`clk`, `rst`, `in` → `rise`, `fall`, combinational from the registered `in_q`) is natural and is reused by other button consumers.
- The FSM and counter live in `button_repeater`.

## Test plan
All scenarios use HOLD_TICKS=10 and REPEAT_TICKS=4.

1. Short press:
   - Stimulus: assert `debounced_in` for 5 cycles, then release.
   - Required: exactly one `step`, one `pressed`, one `released`; `repeating` never high.
2. Long hold:
   - Stimulus: assert `debounced_in` for 30 cycles after the press edge k.
   - Required: `step` pulses at k, k+10, k+14, k+18, k+22, k+26; `repeating` high from k+10 until release.
3. Release on terminal count:
   - Stimulus: drop `debounced_in` so the fall is sampled at edge k+14.
   - Required: no `step` at k+14; `released`=1 at k+14; FSM returns to IDLE.
4. Enable gating:
   - Stimulus: hold the button, drop `enable` at k+5, raise it at k+20 while still held.
   - Required: no `step` after k; no `pressed` on re-enable. A subsequent release and press gives a normal `pressed`/`step`.
5. Async reset mid-repeat:
   - Stimulus: pull `rst` low at k+12, between clock edges.
   - Required: all outputs 0 immediately without waiting for a clock edge. After deassertion with the input held, `pressed`/`step` fire on the first sampled edge.
6. Randomized bounce-free press/release trains (100 events):
   - Required: `pressed` count == `released` count, and `step` count matches the reference model.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for button consumers (repeater, edge detection).
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } repeater_state_t;

  // Defaults for a 12 MHz system clock.
  localparam int unsigned CLK_HZ               = 12_000_000;
  localparam int unsigned DEFAULT_HOLD_TICKS   = 6_000_000;  // 0.5 s
  localparam int unsigned DEFAULT_REPEAT_TICKS = 1_200_000;  // 100 ms

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Registers the previous level and flags rising/falling transitions against it.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic r_in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_in_q <= 1'b0;
    else      r_in_q <= in;
  end

  assign rise = in & ~r_in_q;
  assign fall = ~in & r_in_q;

endmodule

// File: rtl/button_repeater.sv
// Turns a debounced button level into press/repeat step pulses plus press,
// release and repeating indications; every output is registered.
module button_repeater
  import button_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = DEFAULT_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_in,
  input  logic enable,
  output logic step,
  output logic pressed,
  output logic released,
  output logic repeating
);

  localparam int unsigned     CNT_W       = $clog2(max_ticks(HOLD_TICKS, REPEAT_TICKS));
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic            w_rise;
  logic            w_fall;
  repeater_state_t r_state;
  repeater_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic            w_step_nxt;
  logic            w_pressed_nxt;
  logic            w_released_nxt;
  logic            r_step;
  logic            r_pressed;
  logic            r_released;
  logic            r_repeating;

  edge_detector u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (debounced_in),
    .rise (w_rise),
    .fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_step      <= 1'b0;
      r_pressed   <= 1'b0;
      r_released  <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step      <= w_step_nxt;
      r_pressed   <= w_pressed_nxt;
      r_released  <= w_released_nxt;
      r_repeating <= (w_state_nxt == S_REPEAT);
    end
  end

  // Release is tested before the terminal count so it suppresses a coincident step.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = 1'b0;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_step_nxt    = 1'b1;
            w_pressed_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_DELAY;
          end
        end
        S_DELAY: begin
          if (w_fall) begin
            w_released_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_IDLE;
          end else if (r_cnt == HOLD_LAST) begin
            w_step_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            w_released_nxt = 1'b1;
            w_cnt_nxt      = '0;
            w_state_nxt    = S_IDLE;
          end else if (r_cnt == REPEAT_LAST) begin
            w_step_nxt = 1'b1;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign step      = r_step;
  assign pressed   = r_pressed;
  assign released  = r_released;
  assign repeating = r_repeating;

endmodule

// File: tb/tb_button_repeater.sv
// Scoreboard bench: the driver predicts each clock edge from press timing, a monitor compares.
module tb_button_repeater;

  localparam int unsigned H = 10;
  localparam int unsigned R = 4;

  logic clk = 1'b0;
  logic rst;
  logic debounced_in;
  logic enable;
  logic step, pressed, released, repeating;

  int checks = 0;
  int errors = 0;
  int act_step = 0, act_pressed = 0, act_released = 0, act_rep = 0;
  int exp_steps = 0;

  logic [3:0] expq[$];

  // Reference model state: is a press session live, and when did it start.
  bit          m_prev   = 1'b0;
  bit          m_active = 1'b0;
  int unsigned m_edge   = 0;
  int unsigned m_t0     = 0;

  button_repeater #(.HOLD_TICKS(H), .REPEAT_TICKS(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .debounced_in (debounced_in),
    .enable       (enable),
    .step         (step),
    .pressed      (pressed),
    .released     (released),
    .repeating    (repeating)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected {step, pressed, released, repeating} registered at the coming edge.
  task automatic predict(output logic [3:0] e);
    int unsigned el;
    e = '0;
    if (!rst) begin
      m_prev   = 1'b0;
      m_active = 1'b0;
    end else begin
      if (!enable) begin
        m_active = 1'b0;
      end else if (m_active && !debounced_in) begin
        e[1]     = 1'b1;
        m_active = 1'b0;
      end else if (m_active) begin
        el = m_edge - m_t0;
        if (el >= H) begin
          e[0] = 1'b1;
          if (((el - H) % R) == 0) e[3] = 1'b1;
        end
      end else if (debounced_in && !m_prev) begin
        m_active = 1'b1;
        m_t0     = m_edge;
        e[3]     = 1'b1;
        e[2]     = 1'b1;
      end
      m_prev = debounced_in;
    end
    m_edge++;
  endtask

  task automatic drive(input bit d, input bit en, input bit rn);
    logic [3:0] e;
    debounced_in = d;
    enable       = en;
    rst          = rn;
    predict(e);
    expq.push_back(e);
    exp_steps += int'(e[3]);
    @(negedge clk);
  endtask

  task automatic hold(input bit d, input bit en, input int n);
    for (int i = 0; i < n; i++) drive(d, en, 1'b1);
  endtask

  task automatic clear_counts();
    act_step = 0; act_pressed = 0; act_released = 0; act_rep = 0;
  endtask

  // Monitor: one scoreboard entry per clock edge, compared just after the edge.
  initial begin
    logic [3:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        ev = expq.pop_front();
        check("cycle_outputs", {28'd0, step, pressed, released, repeating}, {28'd0, ev});
        act_step     += int'(step);
        act_pressed  += int'(pressed);
        act_released += int'(released);
        act_rep      += int'(repeating);
      end
    end
  end

  initial begin
    int sent;
    rst = 1'b0; debounced_in = 1'b0; enable = 1'b0;
    #1;
    check("reset_outputs", {28'd0, step, pressed, released, repeating}, 32'd0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    hold(0, 1, 3);

    // Short press
    clear_counts();
    hold(1, 1, 5);
    hold(0, 1, 4);
    check("short_steps", act_step, 1);
    check("short_pressed", act_pressed, 1);
    check("short_released", act_released, 1);
    check("short_repeating", act_rep, 0);

    // Long hold: steps at k, k+10, k+14, k+18, k+22, k+26
    clear_counts();
    hold(1, 1, 30);
    hold(0, 1, 4);
    check("long_steps", act_step, 6);
    check("long_repeating_cycles", act_rep, 20);
    check("long_released", act_released, 1);

    // Fall sampled on the repeat terminal edge k+14
    clear_counts();
    hold(1, 1, 14);
    hold(0, 1, 4);
    check("term_steps", act_step, 2);
    check("term_released", act_released, 1);
    check("term_repeating_cycles", act_rep, 4);

    // Enable gating while held
    clear_counts();
    hold(1, 1, 5);
    hold(1, 0, 15);
    hold(1, 1, 20);
    hold(0, 1, 3);
    check("gate_steps", act_step, 1);
    check("gate_pressed", act_pressed, 1);
    check("gate_released", act_released, 0);
    clear_counts();
    hold(1, 1, 3);
    hold(0, 1, 3);
    check("regate_pressed", act_pressed, 1);
    check("regate_steps", act_step, 1);
    check("regate_released", act_released, 1);

    // Async reset mid-repeat, between clock edges
    hold(1, 1, 13);
    check("pre_reset_repeating", {31'd0, repeating}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, step, pressed, released, repeating}, 32'd0);
    drive(1, 1, 0);
    drive(1, 1, 0);
    clear_counts();
    hold(1, 1, 3);
    hold(0, 1, 3);
    check("post_reset_pressed", act_pressed, 1);
    check("post_reset_steps", act_step, 1);

    // Randomized press/release trains (50 presses + 50 releases)
    clear_counts();
    exp_steps = 0;
    sent = 0;
    for (int i = 0; i < 50; i++) begin
      hold(1, 1, int'($urandom_range(40, 1)));
      hold(0, 1, int'($urandom_range(6, 1)));
      sent++;
    end
    hold(0, 1, 2);
    check("rand_pressed", act_pressed, sent);
    check("rand_press_release_balance", act_pressed, act_released);
    check("rand_steps", act_step, exp_steps);
    check("scoreboard_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
